// File: rtl/fp_add_sched_pkg.sv
// Shared state encoding, IEEE-754 double field positions and helpers for the
// shared-adder scheduler.
package fp_add_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int EXP_MSB  = 62;
    localparam int EXP_LSB  = 52;
    localparam int FRAC_MSB = 51;
    localparam int CNT_W    = 4;

    // True for +0 and -0; denormals are not zero.
    function automatic logic is_zero(input logic [63:0] x);
        return (x[EXP_MSB:EXP_LSB] == '0) && (x[FRAC_MSB:0] == '0);
    endfunction

endpackage

// File: rtl/fp_add_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above ptr,
// wrapping around.
module rr_arbiter
    import fp_add_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_sched.sv
// Schedules requester double additions onto one shared external adder,
// one operation in flight; zero operands bypass the adder.
//
// state | meaning
// IDLE  | granting round-robin, no operation in flight
// WAIT  | operands launched to the adder, counting down its latency
// DONE  | response presented, held until rsp_ready
module fp_add_sched
    import fp_add_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*64-1:0]      req_a,
    input  logic [NUM_REQ*64-1:0]      req_b,
    output logic [63:0]                add_a,
    output logic [63:0]                add_b,
    input  logic [63:0]                add_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [63:0]                rsp_data,
    output logic                       busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    xfer_id;
    logic [63:0]        sel_a, sel_b;
    logic               xfer, bypass, armed;

    rr_arbiter #(.N(NUM_REQ), .PW(ID_W)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // armed keeps req_ready low until the first edge after reset release.
    assign req_ready = (state == IDLE && armed) ? grant : '0;
    assign xfer      = |(req_valid & req_ready);
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        xfer_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) xfer_id = ID_W'(i);
        end
    end

    assign sel_a  = req_a[int'(xfer_id)*64 +: 64];
    assign sel_b  = req_b[int'(xfer_id)*64 +: 64];
    assign bypass = is_zero(sel_a) || is_zero(sel_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (xfer) state_nxt = bypass ? DONE : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            ptr      <= '0;
            cnt      <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            add_a    <= '0;
            add_b    <= '0;
        end else begin
            armed <= 1'b1;
            if (xfer) begin
                ptr    <= (xfer_id == ID_W'(NUM_REQ - 1)) ? '0 : xfer_id + 1'b1;
                rsp_id <= xfer_id;
                if (bypass) begin
                    rsp_data <= is_zero(sel_a) ? sel_b : sel_a;
                end else begin
                    add_a <= sel_a;
                    add_b <= sel_b;
                    cnt   <= CNT_W'(ADD_LAT);
                end
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) rsp_data <= add_result;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_sched.sv
// Scoreboard bench for fp_add_sched: random and directed requests against a
// behavioural model, with a latency-accurate external adder model.
module tb_fp_add_sched;

    localparam int NR  = 4;
    localparam int LAT = 2;
    localparam logic [63:0] GARBAGE = 64'h7FF4_DEAD_BEEF_0001;

    typedef struct {
        int          id;
        logic [63:0] data;
        logic        byp;
        int          t;
    } item_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid, req_ready;
    logic [NR*64-1:0] req_a, req_b;
    logic [63:0]      add_a, add_b, add_result, rsp_data;
    logic             rsp_valid, rsp_ready, busy;
    logic [1:0]       rsp_id;

    int          n_chk = 0, n_fail = 0, cyc = 0, mptr = 0, hs_count = 0;
    int          refill = 0, last_lat = 0, last_id = 0;
    logic [63:0] model_la = '0, model_lb = '0, held_data = '0, last_data = '0;
    logic [1:0]  held_id = '0;
    bit          rsp_seen = 0;
    logic [NR-1:0] last_xfer = '0;
    item_t       sb[$];
    int          grant_log[$];

    fp_add_sched #(.NUM_REQ(NR), .ADD_LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) + $bitstoreal(b));
    endfunction

    function automatic logic fzero(input logic [63:0] x);
        return x[62:0] == 63'd0;
    endfunction

    function automatic int model_grant(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [63:0] rand_double();
        logic [63:0] v;
        logic [31:0] hi, lo;
        int unsigned r;
        r  = $urandom_range(0, 7);
        hi = $urandom();
        lo = $urandom();
        if (r == 0)      v = 64'h0;
        else if (r == 1) v = 64'h8000_0000_0000_0000;
        else begin
            v[63]    = hi[31];
            v[62:52] = 11'($urandom_range(1000, 1046));
            v[51:0]  = {hi[19:0], lo};
        end
        return v;
    endfunction

    // External adder: result is garbage until the operands have been stable
    // for LAT-1 full cycles, then the IEEE sum.
    logic [63:0] seen_a = '0, seen_b = '0;
    int          age = 100;
    always @(posedge clk) begin
        if (add_a !== seen_a || add_b !== seen_b) begin
            seen_a = add_a;
            seen_b = add_b;
            age    = 1;
        end else if (age < 100) begin
            age = age + 1;
        end
    end
    always_comb begin
        add_result = GARBAGE;
        if (add_a === seen_a && add_b === seen_b && age >= LAT - 1)
            add_result = fadd(add_a, add_b);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [NR-1:0] xm, er;
        logic [63:0]   a, b;
        int            g;
        item_t         it;
        if (!rst_n) begin
            last_xfer = '0;
        end else begin
            check("busy", 64'(busy), 64'(sb.size() != 0));
            if (sb.size() != 0) begin
                check("ready_while_busy", 64'(req_ready), 64'(0));
            end else if (req_ready != '0) begin
                g  = model_grant(req_valid, mptr);
                er = (g < 0) ? '0 : (NR'(1) << g);
                check("rr_grant", 64'(req_ready), 64'(er));
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid), 64'(0));
                end else begin
                    it = sb[0];
                    if (!rsp_seen) begin
                        last_lat = cyc - it.t;
                        check("rsp_latency", 64'(last_lat), 64'(it.byp ? 1 : LAT + 1));
                        check("rsp_id", 64'(rsp_id), 64'(it.id));
                        check("rsp_data", rsp_data, it.data);
                        check("add_a_hold", add_a, model_la);
                        check("add_b_hold", add_b, model_lb);
                        held_id   = rsp_id;
                        held_data = rsp_data;
                        rsp_seen  = 1;
                    end else begin
                        check("rsp_id_stable", 64'(rsp_id), 64'(held_id));
                        check("rsp_data_stable", rsp_data, held_data);
                    end
                    if (rsp_ready) begin
                        last_data = rsp_data;
                        last_id   = int'(rsp_id);
                        void'(sb.pop_front());
                        rsp_seen = 0;
                        hs_count++;
                    end
                end
            end
            xm = req_valid & req_ready;
            last_xfer = xm;
            if (xm != '0) begin
                check("xfer_onehot", 64'($countones(xm)), 64'(1));
                g = 0;
                for (int k = NR - 1; k >= 0; k--) if (xm[k]) g = k;
                a = req_a[g*64 +: 64];
                b = req_b[g*64 +: 64];
                it.id   = g;
                it.t    = cyc;
                it.byp  = fzero(a) || fzero(b);
                it.data = fzero(a) ? b : (fzero(b) ? a : fadd(a, b));
                if (!it.byp) begin
                    model_la = a;
                    model_lb = b;
                end
                sb.push_back(it);
                grant_log.push_back(g);
                mptr = (g + 1) % NR;
            end
        end
    end

    task automatic issue(input int i, input logic [63:0] a, input logic [63:0] b);
        req_a[i*64 +: 64] = a;
        req_b[i*64 +: 64] = b;
        req_valid[i]      = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (last_xfer[i]) begin
                if (refill > 0) begin
                    issue(i, rand_double(), rand_double());
                    refill--;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((sb.size() != 0 || req_valid != '0) && n < budget) begin
            step();
            n++;
        end
        check({"timeout_", name}, 64'(n < budget), 64'(1));
    endtask

    task automatic flush_model();
        sb.delete();
        mptr      = 0;
        model_la  = '0;
        model_lb  = '0;
        rsp_seen  = 0;
        req_valid = '0;
        refill    = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, "_rsp_id"},    64'(rsp_id), 64'(0));
        check({tag, "_rsp_data"},  rsp_data, 64'(0));
        check({tag, "_add_a"},     add_a, 64'(0));
        check({tag, "_add_b"},     add_b, 64'(0));
        check({tag, "_busy"},      64'(busy), 64'(0));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        flush_model();
        #1;
        check_all_zero("rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        logic [63:0] d0;
        int h0;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        #3;
        check_all_zero("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        rsp_ready = 1'b1;
        issue(0, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000);
        wait_idle(50, "one_plus_one");
        check("one_plus_one_data", last_data, 64'h4000_0000_0000_0000);
        check("one_plus_one_id", 64'(last_id), 64'(0));
        check("one_plus_one_lat", 64'(last_lat), 64'(3));

        issue(1, 64'h0, 64'hC008_0000_0000_0000);
        wait_idle(50, "bypass");
        check("bypass_data", last_data, 64'hC008_0000_0000_0000);
        check("bypass_lat", 64'(last_lat), 64'(1));
        check("bypass_add_a", add_a, 64'h3FF0_0000_0000_0000);
        check("bypass_add_b", add_b, 64'h3FF0_0000_0000_0000);

        pulse_reset();
        grant_log.delete();
        rsp_ready = 1'b1;
        refill    = 1;
        for (int i = 0; i < NR; i++) issue(i, rand_double(), rand_double());
        wait_idle(100, "rr_order");
        check("rr_order_count", 64'(grant_log.size()), 64'(5));
        for (int k = 0; k < 5; k++)
            check("rr_order", 64'(k < grant_log.size() ? grant_log[k] : -1), 64'(k % NR));

        rsp_ready = 1'b0;
        issue(2, 64'h4010_0000_0000_0000, 64'hBFF8_0000_0000_0000);
        n = 0;
        while (!rsp_valid && n < 20) begin step(); n++; end
        check("stall_reach_done", 64'(rsp_valid), 64'(1));
        issue(3, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);
        d0 = rsp_data;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_valid", 64'(rsp_valid), 64'(1));
            check("stall_data", rsp_data, d0);
            check("stall_ready", 64'(req_ready), 64'(0));
            check("stall_busy", 64'(busy), 64'(1));
        end
        h0 = hs_count;
        rsp_ready = 1'b1;
        step();
        step();
        check("stall_one_handshake", 64'(hs_count), 64'(h0 + 1));
        wait_idle(50, "stall_drain");

        for (int c = 0; c < 300; c++) begin
            step();
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0)
                    issue(i, rand_double(), rand_double());
                else if (req_valid[i] && $urandom_range(0, 9) == 0)
                    req_valid[i] = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = 1'b1;
        wait_idle(300, "random_drain");

        issue(3, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000);
        n = 0;
        while (!(busy && !rsp_valid) && n < 20) begin step(); n++; end
        check("abort_reach_wait", 64'(busy && !rsp_valid), 64'(1));
        #1;
        rst_n = 1'b0;
        flush_model();
        #1;
        check_all_zero("abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) step();
        grant_log.delete();
        for (int i = 0; i < NR; i++) issue(i, rand_double(), rand_double());
        wait_idle(100, "post_abort");
        check("first_grant_after_reset",
              64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
